plru_state_ctrl: RTL and testbench

- Owns the per-set pseudo-LRU tree storage for the data cache and acts as the requesting side of the pLRU update engine.
- Accepts hit/miss notifications from the cache controller, reads the set's tree and launches one engine operation.
- Waits for the engine's updated tree, writes it back, and returns the victim way (on misses) to the cache controller.
- Also provides a sequential flush of all trees.

---
 rtl/plru_state_ctrl.sv | 141 ++++++++++++++
 tb/tb_plru_state_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_state_ctrl.sv
// rtl/plru_state_ctrl.sv - per-set pLRU tree storage and request side of the pLRU update engine
module plru_state_ctrl #(
  parameter int SETWAY      = 4,
  parameter int BITS_SETWAY = $clog2(SETWAY),
  parameter int NUM_SETS    = 16,
  parameter int SET_BITS    = $clog2(NUM_SETS),
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SET_BITS-1:0]    req_set,
  input  logic                   req_hit,
  input  logic [BITS_SETWAY-1:0] req_way,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [BITS_SETWAY-1:0] resp_victim,
  output logic                   resp_is_miss,
  output logic                   resp_err,
  input  logic                   flush,
  output logic                   flush_busy,
  output logic [BITS_SETWAY-1:0] eng_line_num,
  output logic [SETWAY-2:0]      eng_btree,
  output logic                   eng_hit,
  output logic                   eng_miss,
  output logic [BITS_SETWAY:0]   eng_lines,
  input  logic [SETWAY-2:0]      eng_btree_in,
  input  logic                   eng_valid,
  input  logic [BITS_SETWAY-1:0] eng_index,
  input  logic                   eng_busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_FLUSH
  } state_t;

  state_t                 state, state_nx;
  logic [SETWAY-2:0]      tree [NUM_SETS];
  logic [SET_BITS-1:0]    set_q;
  logic                   hit_q;
  logic [BITS_SETWAY-1:0] way_q;
  logic [SETWAY-2:0]      btree_q;
  logic [BITS_SETWAY-1:0] line_q;
  logic [TW-1:0]          tcnt;
  logic [SET_BITS-1:0]    fcnt;
  logic                   issue_fire;
  logic                   timed_out;
  logic                   flush_last;

  assign issue_fire = (state == S_ISSUE) && !eng_busy;
  assign timed_out  = (tcnt == TW'(TIMEOUT - 1));
  assign flush_last = (fcnt == SET_BITS'(NUM_SETS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (flush) state_nx = S_FLUSH;
               else if (req_valid) state_nx = S_ISSUE;
      S_ISSUE: if (!eng_busy) state_nx = S_WAIT;
      S_WAIT:  if (eng_valid || timed_out) state_nx = S_RESP;
      S_RESP:  if (resp_ready) state_nx = S_IDLE;
      S_FLUSH: if (flush_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign req_ready  = (state == S_IDLE) && !flush;
  assign resp_valid = (state == S_RESP);
  assign flush_busy = (state == S_FLUSH);
  assign eng_hit    = issue_fire && hit_q;
  assign eng_miss   = issue_fire && !hit_q;
  assign eng_lines  = (BITS_SETWAY + 1)'(SETWAY);
  // Present live values during the launch cycle, then hold what was launched.
  assign eng_btree    = issue_fire ? tree[set_q] : btree_q;
  assign eng_line_num = issue_fire ? way_q : line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      set_q        <= '0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      btree_q      <= '0;
      line_q       <= '0;
      tcnt         <= '0;
      fcnt         <= '0;
      resp_victim  <= '0;
      resp_is_miss <= 1'b0;
      resp_err     <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) tree[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (flush) begin
            fcnt <= '0;
          end else if (req_valid) begin
            set_q <= req_set;
            hit_q <= req_hit;
            way_q <= req_way;
          end
        end
        S_ISSUE: begin
          tcnt <= '0;
          if (!eng_busy) begin
            btree_q <= tree[set_q];
            line_q  <= way_q;
          end
        end
        S_WAIT: begin
          // A result arriving on the timeout cycle is still taken.
          if (eng_valid) begin
            tree[set_q]  <= eng_btree_in;
            resp_victim  <= hit_q ? way_q : eng_index;
            resp_is_miss <= !hit_q;
            resp_err     <= 1'b0;
          end else if (timed_out) begin
            resp_victim  <= '0;
            resp_is_miss <= !hit_q;
            resp_err     <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_FLUSH: begin
          tree[fcnt] <= '0;
          fcnt       <= fcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_state_ctrl.sv
// tb/tb_plru_state_ctrl.sv - directed self-checking bench for plru_state_ctrl
module tb_plru_state_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_set = '0;
  logic       req_hit = 1'b0;
  logic [1:0] req_way = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [1:0] resp_victim;
  logic       resp_is_miss;
  logic       resp_err;
  logic       flush = 1'b0;
  logic       flush_busy;
  logic [1:0] eng_line_num;
  logic [2:0] eng_btree;
  logic       eng_hit;
  logic       eng_miss;
  logic [2:0] eng_lines;
  logic [2:0] eng_btree_in = '0;
  logic       eng_valid = 1'b0;
  logic [1:0] eng_index = '0;
  logic       eng_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  plru_state_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .req_hit(req_hit), .req_way(req_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_victim(resp_victim),
    .resp_is_miss(resp_is_miss), .resp_err(resp_err),
    .flush(flush), .flush_busy(flush_busy),
    .eng_line_num(eng_line_num), .eng_btree(eng_btree), .eng_hit(eng_hit),
    .eng_miss(eng_miss), .eng_lines(eng_lines), .eng_btree_in(eng_btree_in),
    .eng_valid(eng_valid), .eng_index(eng_index), .eng_busy(eng_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [3:0] s, input logic h, input logic [1:0] w);
    req_valid = 1'b1; req_set = s; req_hit = h; req_way = w;
    step();
    req_valid = 1'b0;
    #1;
  endtask

  task automatic engine_return(input logic [2:0] t, input logic [1:0] idx);
    eng_valid = 1'b1; eng_btree_in = t; eng_index = idx;
    step();
    eng_valid = 1'b0;
    #1;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({resp_valid, resp_victim, resp_is_miss, resp_err} !== 5'b0) begin
      errors++; $display("FAIL reset_resp got=%b exp=00000", {resp_valid, resp_victim, resp_is_miss, resp_err}); end
    checks++; if ({flush_busy, eng_hit, eng_miss, eng_line_num, eng_btree} !== 8'b0) begin
      errors++; $display("FAIL reset_eng got=%b exp=00000000", {flush_busy, eng_hit, eng_miss, eng_line_num, eng_btree}); end
    #10 rst = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (eng_lines !== 3'd4) begin errors++; $display("FAIL eng_lines got=%0d exp=4", eng_lines); end
  endtask

  task automatic test_miss();
    start_req(4'd3, 1'b0, 2'd0);
    checks++; if ({eng_miss, eng_hit, eng_btree} !== 5'b10_000) begin
      errors++; $display("FAIL miss_issue got=%b exp=10000", {eng_miss, eng_hit, eng_btree}); end
    step();
    checks++; if ({eng_miss, eng_hit} !== 2'b00) begin
      errors++; $display("FAIL miss_single_pulse got=%b exp=00", {eng_miss, eng_hit}); end
    engine_return(3'b011, 2'd0);
    checks++; if ({resp_valid, resp_victim, resp_is_miss, resp_err} !== 5'b1_00_1_0) begin
      errors++; $display("FAIL miss_resp got=%b exp=10010", {resp_valid, resp_victim, resp_is_miss, resp_err}); end
    ack();
    start_req(4'd3, 1'b1, 2'd1);
    checks++; if ({eng_hit, eng_btree, eng_line_num} !== 6'b1_011_01) begin
      errors++; $display("FAIL miss_writeback got=%b exp=101101", {eng_hit, eng_btree, eng_line_num}); end
    step();
    engine_return(3'b011, 2'd3);
    checks++; if ({resp_victim, resp_is_miss} !== 3'b01_0) begin
      errors++; $display("FAIL hit_echo got=%b exp=010", {resp_victim, resp_is_miss}); end
    ack();
  endtask

  task automatic test_hit();
    start_req(4'd5, 1'b1, 2'd2);
    checks++; if ({eng_hit, eng_miss, eng_line_num, eng_btree} !== 7'b1_0_10_000) begin
      errors++; $display("FAIL hit_issue got=%b exp=1010000", {eng_hit, eng_miss, eng_line_num, eng_btree}); end
    step();
    checks++; if ({eng_line_num, eng_btree} !== 5'b10_000) begin
      errors++; $display("FAIL hit_hold got=%b exp=10000", {eng_line_num, eng_btree}); end
    engine_return(3'b101, 2'd3);
    checks++; if ({resp_valid, resp_victim, resp_is_miss, resp_err} !== 5'b1_10_0_0) begin
      errors++; $display("FAIL hit_resp got=%b exp=11000", {resp_valid, resp_victim, resp_is_miss, resp_err}); end
    ack();
    start_req(4'd5, 1'b1, 2'd0);
    checks++; if (eng_btree !== 3'b101) begin errors++; $display("FAIL hit_tree5 got=%b exp=101", eng_btree); end
    step();
    engine_return(3'b101, 2'd0);
    ack();
  endtask

  task automatic test_busy();
    eng_busy = 1'b1;
    start_req(4'd1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({eng_hit, eng_miss} !== 2'b00) begin
        errors++; $display("FAIL busy_hold cyc=%0d got=%b exp=00", i, {eng_hit, eng_miss}); end
      if (i < 2) step();
    end
    eng_busy = 1'b0;
    #1;
    checks++; if ({eng_hit, eng_miss} !== 2'b01) begin
      errors++; $display("FAIL busy_release got=%b exp=01", {eng_hit, eng_miss}); end
    step();
    checks++; if ({eng_hit, eng_miss} !== 2'b00) begin
      errors++; $display("FAIL busy_one_pulse got=%b exp=00", {eng_hit, eng_miss}); end
    engine_return(3'b010, 2'd2);
    checks++; if (resp_victim !== 2'd2) begin errors++; $display("FAIL busy_victim got=%0d exp=2", resp_victim); end
    ack();
  endtask

  task automatic test_resp_hold();
    start_req(4'd7, 1'b0, 2'd0);
    step();
    engine_return(3'b110, 2'd3);
    req_valid = 1'b1; req_set = 4'd9; req_hit = 1'b1; req_way = 2'd1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({resp_valid, req_ready, resp_victim, resp_is_miss, resp_err} !== 6'b1_0_11_1_0) begin
        errors++; $display("FAIL resp_hold cyc=%0d got=%b exp=101110", i,
                           {resp_valid, req_ready, resp_victim, resp_is_miss, resp_err}); end
      step();
    end
    req_valid = 1'b0;
    ack();
    checks++; if ({resp_valid, req_ready, eng_hit, eng_miss} !== 4'b0100) begin
      errors++; $display("FAIL resp_release got=%b exp=0100", {resp_valid, req_ready, eng_hit, eng_miss}); end
  endtask

  task automatic test_timeout();
    int n;
    start_req(4'd7, 1'b0, 2'd0);
    checks++; if (eng_btree !== 3'b110) begin errors++; $display("FAIL to_tree_in got=%b exp=110", eng_btree); end
    step();
    n = 0;
    while (!resp_valid && n < 200) begin step(); n++; end
    checks++; if (n != 64) begin errors++; $display("FAIL to_cycles got=%0d exp=64", n); end
    checks++; if ({resp_victim, resp_is_miss, resp_err} !== 4'b00_1_1) begin
      errors++; $display("FAIL to_resp got=%b exp=0011", {resp_victim, resp_is_miss, resp_err}); end
    ack();
    start_req(4'd7, 1'b1, 2'd2);
    checks++; if (eng_btree !== 3'b110) begin errors++; $display("FAIL to_tree_kept got=%b exp=110", eng_btree); end
    step();
    engine_return(3'b110, 2'd0);
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL to_err_clear got=%b exp=0", resp_err); end
    ack();
  endtask

  task automatic test_flush();
    int n;
    flush = 1'b1;
    req_valid = 1'b1; req_set = 4'd5; req_hit = 1'b1; req_way = 2'd0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
    step();
    flush = 1'b0;
    n = 0;
    while (flush_busy && n < 100) begin n++; step(); end
    checks++; if (n != 16) begin errors++; $display("FAIL flush_cycles got=%0d exp=16", n); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_done_ready got=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    #1;
    checks++; if ({eng_hit, eng_btree} !== 4'b1_000) begin
      errors++; $display("FAIL flush_tree5 got=%b exp=1000", {eng_hit, eng_btree}); end
    step();
    engine_return(3'b001, 2'd0);
    ack();
    start_req(4'd3, 1'b0, 2'd0);
    checks++; if (eng_btree !== 3'b000) begin errors++; $display("FAIL flush_tree3 got=%b exp=000", eng_btree); end
    step();
    engine_return(3'b111, 2'd1);
    ack();
  endtask

  task automatic test_reset_mid();
    start_req(4'd3, 1'b0, 2'd0);
    checks++; if (eng_btree !== 3'b111) begin errors++; $display("FAIL rm_pre_tree got=%b exp=111", eng_btree); end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if ({resp_valid, resp_victim, resp_is_miss, resp_err, flush_busy, eng_hit, eng_miss, eng_line_num, eng_btree} !== 13'b0) begin
      errors++; $display("FAIL rm_outputs got=%b exp=0", {resp_valid, resp_victim, resp_is_miss, resp_err,
                         flush_busy, eng_hit, eng_miss, eng_line_num, eng_btree}); end
    #3 rst = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%b exp=1", req_ready); end
    start_req(4'd3, 1'b0, 2'd0);
    checks++; if ({eng_miss, eng_btree} !== 4'b1_000) begin
      errors++; $display("FAIL rm_tree_clear got=%b exp=1000", {eng_miss, eng_btree}); end
    step();
    engine_return(3'b010, 2'd1);
    checks++; if ({resp_valid, resp_victim} !== 3'b1_01) begin
      errors++; $display("FAIL rm_resp got=%b exp=101", {resp_valid, resp_victim}); end
    ack();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_busy();
    test_resp_hold();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
